uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Asynchronous serial receiver (8N1, LSB first) for the USB-serial rxd pin.
//   Replaces the board's direct rxd->txd loopback on the receive side.
//   Delivers bytes to fabric/SOPC logic via a one-entry valid/ready buffer.
//   Flags framing errors and overruns.
// PARAMETERS
//   CLK_FREQ  16.0e6  real; clk frequency in Hz
//   BAUD      115200  real; line rate in bit/s
//   BIT_DIV   round(CLK_FREQ/BAUD) = 139  localparam; clk cycles per bit; elaboration fatal if < 8
//   CW        $clog2(BIT_DIV)  localparam; bit-timer width
// PORTS
//   clk          in   1  system clock
//   rst          in   1  synchronous reset, active high
//   rxd          in   1  asynchronous serial input, idle high
//   rx_data      out  8  received byte, valid while rx_valid=1
//   rx_valid     out  1  byte available
//   rx_ready     in   1  consumer accepts; transfer on rx_valid & rx_ready
//   rx_ferr      out  1  one-cycle pulse: stop bit sampled low
//   rx_overrun   out  1  one-cycle pulse: new byte dropped, buffer full
//   busy         out  1  1 whenever state != IDLE
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Reset values: rx_data=0x00, rx_valid=0, rx_ferr=0, rx_overrun=0, busy=0.
//     Synchronizer flops reset to 1. State resets to IDLE. Bit timer and bit count reset to 0.
//   rxd passes through a 2-flop synchronizer; rxs is its output. All decisions use rxs only.
//   FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
//   IDLE:  when rxs==0, go to START; timer <= BIT_DIV/2-1.
//   START: timer counts down to 0 (mid start bit). Then:
//          rxs==0 -> DATA; timer <= BIT_DIV-1; bitcnt <= 0.
//          rxs==1 -> IDLE (glitch reject, no flag).
//   DATA:  at each timer==0: shift rxs into shreg[7] (shift right), reload BIT_DIV-1.
//          After the 8th sample, go to STOP.
//   STOP:  at timer==0 (mid stop bit):
//          rxs==1 -> byte done, go to IDLE.
//          rxs==0 -> rx_ferr pulse, byte discarded, go to WAIT_HIGH.
//   WAIT_HIGH: stay until rxs==1, then go to IDLE (a held-low/break line never restarts).
//   Byte done -> on the next cycle: rx_data=shreg and rx_valid=1.
//     Latency: at most 1 cycle after the mid-stop sample.
//   Handshake: rx_valid stays high and rx_data stays stable until rx_valid & rx_ready.
//     After the transfer, rx_valid falls on the next cycle unless a new byte loads.
//   Byte done while rx_valid=1 and rx_ready=1 in the same cycle:
//     old byte transfers, new byte loads, rx_valid stays 1, no overrun.
//   Byte done while rx_valid=1 and rx_ready=0:
//     new byte dropped, old byte kept, rx_overrun pulse.
//   Byte done with rx_ferr: never loads the buffer.
//   rst in mid-frame: abandon the frame immediately, return to IDLE.
//     Remaining frame bits may mis-frame. Correct reception is required after >= 1 idle-high bit time.
//   Timer arithmetic: unsigned CW bits; reload only, never wraps below 0.
// STRUCTURE
//   uart_pkg: state enum type (uart_rx_state_t); function bit_div(clk_freq, baud) with rounding.
//   One sub-module: bit_sync (2-flop synchronizer; parameter RESET_VAL = 1'b1).
//   This block holds the FSM, bit timer, shift register and output buffer.
// TESTING
//   1. rx_ready=1; send 0x55 at BIT_DIV=139 -> one rx_valid cycle, rx_data=0x55, no ferr/overrun.
//   2. rxd low for 40 cycles, then high -> no rx_valid, no rx_ferr; busy returns to 0.
//   3. Send 0xA5 with stop bit=0 -> rx_ferr pulse, rx_valid stays 0.
//      Hold rxd low 500 cycles, then idle -> no spurious byte; next byte 0x3C received as 0x3C.
//   4. rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun pulses once at 0x22 stop.
//      Then rx_ready=1 -> 0x11 transfers, rx_valid falls.
//   5. Send 0x00 and 0xFF at 135 and at 143 cycles/bit (about +/-3%) -> all four bytes correct.
//   6. Assert rst for 1 cycle during DATA bit 4 -> all outputs at reset values.
//      After one idle bit time, send 0x81 -> received as 0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 serial receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_rx_state_t;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int bit_div(input real clk_freq, input real baud);
    return $rtoi(clk_freq / baud + 0.5);
  endfunction

endpackage

// File: rtl/uart_rx_bit_sync.sv
// Two-flop synchronizer for a single asynchronous input.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter: two back-to-back flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first serial receiver with a one-entry valid/ready output buffer,
// framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter real CLK_FREQ = 16.0e6,
  parameter real BAUD     = 115200.0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_ferr,
  output logic       rx_overrun,
  output logic       busy
);

  localparam int BIT_DIV = bit_div(CLK_FREQ, BAUD);
  localparam int CW      = $clog2(BIT_DIV);
  localparam logic [CW-1:0] FULL_C = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] HALF_C = CW'(BIT_DIV / 2 - 1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  if (BIT_DIV < 8) begin : g_bad_div
    $fatal(1, "uart_rx: BIT_DIV must be at least 8");
  end

  logic           rxs_s;
  uart_rx_state_t state_r, state_next_s;
  logic [CW-1:0]  timer_r, timer_next_s;
  logic [2:0]     bitcnt_r, bitcnt_next_s;
  logic [7:0]     shreg_r, shreg_next_s;
  logic           byte_done_s;
  logic           ferr_s;
  logic [7:0]     rx_data_r;
  logic           rx_valid_r;
  logic           rx_ferr_r;
  logic           rx_overrun_r;
  logic           busy_r;

  bit_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs_s)
  );

  // Frame FSM state, bit timer, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      timer_r  <= ZERO_C;
      bitcnt_r <= 3'd0;
      shreg_r  <= 8'h00;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      timer_r  <= timer_next_s;
      bitcnt_r <= bitcnt_next_s;
      shreg_r  <= shreg_next_s;
      busy_r   <= (state_next_s != ST_IDLE);
    end
  end

  // Next-state logic; every sample is taken at timer==0, i.e. mid-bit.
  always_comb begin
    state_next_s  = state_r;
    timer_next_s  = timer_r;
    bitcnt_next_s = bitcnt_r;
    shreg_next_s  = shreg_r;
    byte_done_s   = 1'b0;
    ferr_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rxs_s) begin
          state_next_s = ST_START;
          timer_next_s = HALF_C;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_r != ZERO_C) begin
          timer_next_s = timer_r - ONE_C;
        end else if (!rxs_s) begin
          state_next_s  = ST_DATA;
          timer_next_s  = FULL_C;
          bitcnt_next_s = 3'd0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (timer_r != ZERO_C) begin
          timer_next_s = timer_r - ONE_C;
        end else begin
          shreg_next_s = {rxs_s, shreg_r[7:1]};
          timer_next_s = FULL_C;
          if (bitcnt_r == 3'd7) begin
            state_next_s = ST_STOP;
          end else begin
            bitcnt_next_s = bitcnt_r + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (timer_r != ZERO_C) begin
          timer_next_s = timer_r - ONE_C;
        end else if (rxs_s) begin
          byte_done_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          ferr_s       = 1'b1;
          state_next_s = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxs_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // One-entry output buffer; a consumer pop in the same cycle frees room for a new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_r    <= 8'h00;
      rx_valid_r   <= 1'b0;
      rx_ferr_r    <= 1'b0;
      rx_overrun_r <= 1'b0;
    end else begin
      rx_ferr_r    <= ferr_s;
      rx_overrun_r <= 1'b0;
      if (byte_done_s && (!rx_valid_r || rx_ready)) begin
        rx_data_r  <= shreg_r;
        rx_valid_r <= 1'b1;
      end else if (byte_done_s) begin
        rx_overrun_r <= 1'b1;
      end else if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
    end
  end

  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign rx_ferr    = rx_ferr_r;
  assign rx_overrun = rx_overrun_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, a monitor pops expected bytes on each transfer.
module tb_uart_rx;

  localparam int BIT_C = 139;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_ferr;
  logic       rx_overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int valid_cycles = 0;
  int ferr_cnt     = 0;
  int ov_cnt       = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLK_FREQ(16.0e6), .BAUD(115200.0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_ferr    (rx_ferr),
    .rx_overrun (rx_overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, {24'h0, rx_data}, 32'h00);
    chk({tag, "_valid"}, {31'h0, rx_valid}, 32'h0);
    chk({tag, "_ferr"}, {31'h0, rx_ferr}, 32'h0);
    chk({tag, "_overrun"}, {31'h0, rx_overrun}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  // Drive one frame; rst_bit >= 0 pulses rst for one cycle in the middle of that data bit.
  task automatic send(input logic [7:0] b, input int per, input logic stop_bit, input int rst_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      if (rst_bit >= 0 && i == rst_bit + 1) begin
        tick(per / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_reset_vals("midframe_rst");
        tick(per - per / 2 - 1);
      end else begin
        tick(per);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and tallies pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) valid_cycles++;
      if (rx_ferr) ferr_cnt++;
      if (rx_overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          chk("rx_byte", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    int v0;
    int f0;
    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b1;
    tick(4);
    chk_reset_vals("reset");
    rst = 1'b0;
    tick(20);

    // 1: single byte with consumer ready
    v0 = valid_cycles;
    exp_q.push_back(8'h55);
    send(8'h55, BIT_C, 1'b1, -1);
    tick(BIT_C);
    chk("t1_valid_cycles", valid_cycles - v0, 32'd1);
    chk("t1_ferr", ferr_cnt, 32'd0);
    chk("t1_overrun", ov_cnt, 32'd0);

    // 2: short low glitch is rejected
    v0 = valid_cycles;
    rxd = 1'b0;
    tick(40);
    rxd = 1'b1;
    tick(200);
    chk("t2_valid_cycles", valid_cycles - v0, 32'd0);
    chk("t2_ferr", ferr_cnt, 32'd0);
    chk("t2_busy", {31'h0, busy}, 32'h0);

    // 3: framing error, held-low line, then recovery
    v0 = valid_cycles;
    send(8'hA5, BIT_C, 1'b0, -1);
    tick(500);
    chk("t3_ferr_pulse", ferr_cnt, 32'd1);
    chk("t3_busy_in_break", {31'h0, busy}, 32'h1);
    rxd = 1'b1;
    tick(BIT_C);
    chk("t3_no_byte", valid_cycles - v0, 32'd0);
    exp_q.push_back(8'h3C);
    send(8'h3C, BIT_C, 1'b1, -1);
    tick(BIT_C);
    chk("t3_ferr_after", ferr_cnt, 32'd1);

    // 4: overrun while consumer stalled
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send(8'h11, BIT_C, 1'b1, -1);
    tick(BIT_C);
    chk("t4_valid_held", {31'h0, rx_valid}, 32'h1);
    chk("t4_no_overrun_yet", ov_cnt, 32'd0);
    send(8'h22, BIT_C, 1'b1, -1);
    tick(BIT_C);
    chk("t4_overrun_once", ov_cnt, 32'd1);
    chk("t4_data_kept", {24'h0, rx_data}, 32'h11);
    chk("t4_valid_still", {31'h0, rx_valid}, 32'h1);
    rx_ready = 1'b1;
    tick(2);
    chk("t4_valid_fell", {31'h0, rx_valid}, 32'h0);

    // 5: baud tolerance at about -3% and +3%
    exp_q.push_back(8'h00);
    send(8'h00, 135, 1'b1, -1);
    tick(135);
    exp_q.push_back(8'hFF);
    send(8'hFF, 135, 1'b1, -1);
    tick(135);
    exp_q.push_back(8'h00);
    send(8'h00, 143, 1'b1, -1);
    tick(143);
    exp_q.push_back(8'hFF);
    send(8'hFF, 143, 1'b1, -1);
    tick(143);
    chk("t5_all_popped", exp_q.size(), 32'd0);

    // 6: reset mid-frame, then clean reception
    v0 = valid_cycles;
    f0 = ferr_cnt;
    send(8'hF0, BIT_C, 1'b1, 4);
    tick(BIT_C);
    chk("t6_no_byte", valid_cycles - v0, 32'd0);
    chk("t6_no_ferr", ferr_cnt - f0, 32'd0);
    exp_q.push_back(8'h81);
    send(8'h81, BIT_C, 1'b1, -1);
    tick(BIT_C);

    chk("end_queue_empty", exp_q.size(), 32'd0);
    chk("end_ferr_total", ferr_cnt, 32'd1);
    chk("end_overrun_total", ov_cnt, 32'd1);
    chk("end_busy", {31'h0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
